// File: rtl/button_pkg.sv
// Shared definitions for the board button / LED blocks.
//   state_t      : debounce FSM states.
//   BOARD_CLK_HZ : board oscillator frequency, used to scale time constants.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam int BOARD_CLK_HZ = 27000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clk : destination clock
//   rst : synchronous active-high reset, loads RESET_VAL into both flops
//   d   : asynchronous input
//   q   : input resynchronised into clk (two cycles of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= {2{RESET_VAL}};
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronises and debounces one raw pin and
// produces clean single-cycle events plus level outputs.
//   clk           : system clock
//   rst           : synchronous active-high reset
//   btn           : raw asynchronous button pin
//   pressed       : debounced level, 1 while held
//   press_pulse   : one-cycle pulse per accepted press
//   release_pulse : one-cycle pulse per accepted release
//   long_pulse    : one-cycle pulse when a hold reaches LONG_CYCLES
//   toggle        : flips on every accepted press
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BOARD_CLK_HZ / 100,
  parameter int LONG_CYCLES     = BOARD_CLK_HZ,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic toggle
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES - 1);

  logic raw;
  logic s;

  state_t        state_reg, state_next;
  logic [DW-1:0] dcnt_reg, dcnt_next;
  logic [HW-1:0] hcnt_reg, hcnt_next;
  logic          pressed_reg, pressed_next;
  logic          press_reg, press_next;
  logic          release_reg, release_next;
  logic          long_reg, long_next;
  logic          toggle_reg, toggle_next;
  logic          hold_advance;

  // Normalise so that 1 always means "pressed".
  assign raw = btn ^ ACTIVE_LOW;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (raw),
    .q  (s)
  );

  always_comb begin
    state_next   = state_reg;
    dcnt_next    = dcnt_reg;
    hcnt_next    = hcnt_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    toggle_next  = toggle_reg;
    hold_advance = 1'b0;

    case (state_reg)
      IDLE: begin
        if (s) begin
          dcnt_next  = '0;
          state_next = PRESS_CHK;
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_next = IDLE;
        end else if (dcnt_reg == DCNT_LAST) begin
          state_next  = HELD;
          press_next  = 1'b1;
          toggle_next = ~toggle_reg;
          hcnt_next   = '0;
        end else begin
          dcnt_next = dcnt_reg + 1'b1;
        end
      end
      HELD: begin
        // The hold timer runs every cycle until a release is accepted, so
        // short glitches do not shift the long-press point.
        hold_advance = 1'b1;
        if (!s) begin
          dcnt_next  = '0;
          state_next = RELEASE_CHK;
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_next   = HELD;
          hold_advance = 1'b1;
        end else if (dcnt_reg == DCNT_LAST) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else begin
          dcnt_next    = dcnt_reg + 1'b1;
          hold_advance = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Saturating hold counter; the pulse fires only on the step into the
    // saturation value, hence once per press.
    if (hold_advance && (hcnt_reg != HCNT_MAX)) begin
      hcnt_next = hcnt_reg + 1'b1;
      long_next = (hcnt_reg == HCNT_LAST);
    end
  end

  assign pressed_next = (state_next == HELD) || (state_next == RELEASE_CHK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      dcnt_reg    <= '0;
      hcnt_reg    <= '0;
      pressed_reg <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      long_reg    <= 1'b0;
      toggle_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dcnt_reg    <= dcnt_next;
      hcnt_reg    <= hcnt_next;
      pressed_reg <= pressed_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      long_reg    <= long_next;
      toggle_reg  <= toggle_next;
    end
  end

  assign pressed       = pressed_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign long_pulse    = long_reg;
  assign toggle        = toggle_reg;

endmodule
